// File: rtl/pipe_if_stage_pkg.sv
// Shared CPU definitions for the fetch stage: next-PC select codes, reset PC,
// the squash instruction word and a word-alignment helper.
package pipe_if_stage_pkg;

   typedef enum logic [1:0] {
      PCSRC_SEQ = 2'b00,
      PCSRC_BR  = 2'b01,
      PCSRC_JR  = 2'b10,
      PCSRC_J   = 2'b11
   } pcsrc_e;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;  // sll r0,r0,0

   function automatic logic [31:0] align_pc(input logic [31:0] a);
      return a & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/pipe_if_stage_if.sv
// Fetch-stage bus: redirect/stall controls from ID, the instruction memory
// port, and the IF/ID register outputs consumed by decode.
interface pipe_if_stage_if;

   logic        wpcir;
   logic [1:0]  pcsrc;
   logic [31:0] bpc;
   logic [31:0] rpc;
   logic [31:0] jpc;
   logic [31:0] imem_data;
   logic [31:0] imem_addr;
   logic [31:0] dpc4;
   logic [31:0] dinst;

   // The fetch stage itself.
   modport slave (
      input  wpcir, pcsrc, bpc, rpc, jpc, imem_data,
      output imem_addr, dpc4, dinst
   );

   // The surroundings: ID stage controls and the instruction memory.
   modport master (
      output wpcir, pcsrc, bpc, rpc, jpc, imem_data,
      input  imem_addr, dpc4, dinst
   );

endinterface

// File: rtl/dffe32.sv
// 32-bit enable-gated register with asynchronous active-low clear to RST_VAL.
module dffe32 #(
   parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        e,
   input  logic [31:0] d,
   output logic [31:0] q
);

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples its inputs before any of them update on the same edge.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)  q <= RST_VAL;
      else if (e) q <= d;
   end

endmodule

// File: rtl/pc_next_mux.sv
// Next-PC selector: 4:1 choice of sequential/branch/jr/jump target, with the
// result forced word-aligned before it reaches the PC register.
module pc_next_mux
   import pipe_if_stage_pkg::*;
(
   input  logic [1:0]  pcsrc,
   input  logic [31:0] pc4,
   input  logic [31:0] bpc,
   input  logic [31:0] rpc,
   input  logic [31:0] jpc,
   output logic [31:0] npc
);

   logic [31:0] sel;

   // NOTE: sel gets a default before the case so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      sel = pc4;
      unique case (pcsrc_e'(pcsrc))
         PCSRC_SEQ: sel = pc4;
         PCSRC_BR:  sel = bpc;
         PCSRC_JR:  sel = rpc;
         PCSRC_J:   sel = jpc;
      endcase
      npc = align_pc(sel);
   end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC register, PC+4, next-PC mux and IF/ID register.
// Build option IF_FLUSH_EN squashes the slot after a taken redirect to NOP_WORD.
module pipe_if_stage
   import pipe_if_stage_pkg::*;
(
   input  logic            clk,
   input  logic            clrn,
   pipe_if_stage_if.slave  bus
);

   logic [31:0] pc;
   logic [31:0] pc4;
   logic [31:0] npc;
   logic [31:0] inst_d;

   assign pc4           = pc + 32'd4;
   assign bus.imem_addr = pc;

`ifdef IF_FLUSH_EN
   // Taken redirect: the word fetched alongside it is discarded (no delay slot).
   assign inst_d = (pcsrc_e'(bus.pcsrc) != PCSRC_SEQ) ? NOP_WORD : bus.imem_data;
`else
   assign inst_d = bus.imem_data;
`endif

   pc_next_mux u_next (
      .pcsrc (bus.pcsrc),
      .pc4   (pc4),
      .bpc   (bus.bpc),
      .rpc   (bus.rpc),
      .jpc   (bus.jpc),
      .npc   (npc)
   );

   // wpcir low stalls PC and IF/ID together so the pair stays consistent.
   dffe32 #(.RST_VAL(RESET_PC)) u_pc (
      .clk  (clk),
      .clrn (clrn),
      .e    (bus.wpcir),
      .d    (npc),
      .q    (pc)
   );

   dffe32 u_dpc4 (
      .clk  (clk),
      .clrn (clrn),
      .e    (bus.wpcir),
      .d    (pc4),
      .q    (bus.dpc4)
   );

   dffe32 u_dinst (
      .clk  (clk),
      .clrn (clrn),
      .e    (bus.wpcir),
      .d    (inst_d),
      .q    (bus.dinst)
   );

endmodule

// File: tb/tb_pipe_if_stage.sv
// Scoreboard bench for pipe_if_stage: directed vectors push hand-computed
// {pc, dpc4, dinst} expectations; a negedge monitor pops and compares.
module tb_pipe_if_stage;
   import pipe_if_stage_pkg::*;

`ifdef IF_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] dpc4;
      logic [31:0] dinst;
   } exp_t;

   logic clk  = 1'b0;
   logic clrn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   pipe_if_stage_if bus ();

   pipe_if_stage dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Instruction memory: word i holds value i.
   assign bus.imem_data = {2'b00, bus.imem_addr[31:2]};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Monitor: outputs are registered, so mid-cycle (negedge) sampling is stable.
   initial begin
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, ".pc"},    bus.imem_addr, e.pc);
            check({e.name, ".dpc4"},  bus.dpc4,      e.dpc4);
            check({e.name, ".dinst"}, bus.dinst,     e.dinst);
         end
      end
   end

   // Called at a negedge: drive inputs, take one rising edge, queue expectation.
   task automatic vec(input string name, input logic w, input logic [1:0] src,
                      input logic [31:0] target, input logic [31:0] epc,
                      input logic [31:0] edpc4, input logic [31:0] edinst);
      bus.wpcir = w;
      bus.pcsrc = src;
      bus.bpc   = target;
      bus.rpc   = target;
      bus.jpc   = target;
      @(posedge clk);
      sb_q.push_back('{name, epc, edpc4, edinst});
      @(negedge clk);
   endtask

   function automatic logic [31:0] sq(input logic [31:0] word);
      return FLUSH ? NOP_WORD : word;
   endfunction

   initial begin
      bus.wpcir = 1'b1;
      bus.pcsrc = 2'b00;
      bus.bpc   = '0;
      bus.rpc   = '0;
      bus.jpc   = '0;
      sb_q.push_back('{"reset", 32'h0, 32'h0, 32'h0});
      @(negedge clk);
      clrn = 1'b1;

      vec("seq0",   1, 2'b00, 32'h0,   32'h4,   32'h4,   32'h0);
      vec("seq1",   1, 2'b00, 32'h0,   32'h8,   32'h8,   32'h1);
      for (int i = 0; i < 3; i++)
         vec("stall", 0, 2'b00, 32'h0, 32'h8,   32'h8,   32'h1);
      vec("resume", 1, 2'b00, 32'h0,   32'hC,   32'hC,   32'h2);
      vec("br",     1, 2'b01, 32'h40,  32'h40,  32'h10,  sq(32'h3));
      vec("br_tgt", 1, 2'b00, 32'h0,   32'h44,  32'h44,  32'h10);
      vec("jr_aln", 1, 2'b10, 32'h107, 32'h104, 32'h48,  sq(32'h11));
      vec("jr_tgt", 1, 2'b00, 32'h0,   32'h108, 32'h108, 32'h41);
      vec("j_top",  1, 2'b11, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h10C, sq(32'h42));
      vec("wrap",   1, 2'b00, 32'h0,   32'h0,   32'h0,   32'h3FFF_FFFF);
      vec("seq2",   1, 2'b00, 32'h0,   32'h4,   32'h4,   32'h0);
      vec("br_aln", 1, 2'b01, 32'h22,  32'h20,  32'h8,   sq(32'h1));
      vec("stl_j0", 0, 2'b11, 32'h80,  32'h20,  32'h8,   sq(32'h1));
      vec("stl_j1", 0, 2'b11, 32'h80,  32'h20,  32'h8,   sq(32'h1));

      // Asynchronous reset in the middle of a stalled jump; held across an edge.
      bus.wpcir = 1'b1;
      #2 clrn = 1'b0;
      #1 sb_q.push_back('{"async_rst", 32'h0, 32'h0, 32'h0});
      @(negedge clk);
      @(negedge clk);
      clrn = 1'b1;
      vec("post_rst", 1, 2'b00, 32'h0, 32'h4, 32'h4, 32'h0);
      vec("post_rs2", 1, 2'b00, 32'h0, 32'h8, 32'h8, 32'h1);

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded 20000 ns, expected completion");
      $fatal(1);
   end

endmodule
